// File: rtl/load_pkg.sv
// Shared types for the MEM-stage load path: load types, fault causes,
// FSM states, default bus timeout and small decode helpers.
package load_pkg;

  typedef enum logic [2:0] {
    LT_LB  = 3'b000,
    LT_LH  = 3'b001,
    LT_LW  = 3'b010,
    LT_LBU = 3'b100,
    LT_LHU = 3'b101
  } ld_type_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISALIGN = 2'b01,
    CAUSE_TIMEOUT  = 2'b10,
    CAUSE_ILLEGAL  = 2'b11
  } cause_e;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_e;

  localparam int DEFAULT_TIMEOUT = 255;

  function automatic logic is_legal(
    input logic [2:0] t
  );
    return (t == LT_LB)  || (t == LT_LH)
        || (t == LT_LW)  || (t == LT_LBU)
        || (t == LT_LHU);
  endfunction

  // t[1:0]==01 covers both LH and LHU
  function automatic logic is_misaligned(
    input logic [2:0] t,
    input logic [1:0] off
  );
    return ((t[1:0] == 2'b01) && off[0])
        || ((t == LT_LW) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/load_data_extractor.sv
// Combinational byte/half/word select and sign/zero extension of a read word.
// Ports: ld_type, off (addr[1:0]), rdata in; data (extended result) out.
module load_data_extractor
  import load_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        ld_type,
  input  logic [1:0]        off,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b    = rdata[8*off +: 8];
    h    = rdata[16*off[1] +: 16];
    data = rdata;
    unique case (1'b1)
      ld_type == LT_LB:
        data = {{(DATA_W-8){b[7]}}, b};
      ld_type == LT_LBU:
        data = {{(DATA_W-8){1'b0}}, b};
      ld_type == LT_LH:
        data = {{(DATA_W-16){h[15]}}, h};
      ld_type == LT_LHU:
        data = {{(DATA_W-16){1'b0}}, h};
      default:
        data = rdata;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// MEM-stage load unit: word-aligned read request, extraction, fault reporting.
// Ports: ld_* request, mem_* data-memory read bus, rsp_* writeback response.
// Option: LOAD_MISALIGN_TRAP_EN makes misaligned LH/LHU/LW fault with cause 01.
module load_unit
  import load_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [2:0]        ld_type,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [4:0]        ld_rd,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [4:0]        rsp_rd,
  output logic              rsp_fault,
  output logic [1:0]        rsp_cause
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e            state;
  logic [2:0]        typ;
  logic [1:0]        off;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] ext;
  logic              tmo;
  logic              misal;

  assign ld_ready  = (state == IDLE);
  assign mem_req   = (state == REQ);
  assign rsp_valid = (state == RESP);

  // cnt holds cycles already spent; this cycle is number cnt+1
  assign tmo = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

`ifdef LOAD_MISALIGN_TRAP_EN
  assign misal = is_misaligned(ld_type, ld_addr[1:0]);
`else
  assign misal = 1'b0;
`endif

  load_data_extractor #(
    .DATA_W (DATA_W)
  ) u_ext (
    .ld_type (typ),
    .off     (off),
    .rdata   (mem_rdata),
    .data    (ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_addr  <= '0;
      rsp_data  <= '0;
      rsp_rd    <= '0;
      rsp_fault <= 1'b0;
      rsp_cause <= CAUSE_NONE;
      typ       <= '0;
      off       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ld_valid) begin
            typ      <= ld_type;
            off      <= ld_addr[1:0];
            rsp_rd   <= ld_rd;
            rsp_data <= '0;
            cnt      <= '0;
            if (!is_legal(ld_type)) begin
              state     <= RESP;
              rsp_fault <= 1'b1;
              rsp_cause <= CAUSE_ILLEGAL;
            end else if (misal) begin
              state     <= RESP;
              rsp_fault <= 1'b1;
              rsp_cause <= CAUSE_MISALIGN;
            end else begin
              state     <= REQ;
              mem_addr  <= {ld_addr[ADDR_W-1:2], 2'b00};
              rsp_fault <= 1'b0;
              rsp_cause <= CAUSE_NONE;
            end
          end
        end
        REQ: begin
          cnt <= cnt + 1'b1;
          if (tmo) begin
            state     <= RESP;
            rsp_fault <= 1'b1;
            rsp_cause <= CAUSE_TIMEOUT;
            rsp_data  <= '0;
          end else if (mem_gnt) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          // timeout beats a same-cycle rvalid
          if (tmo) begin
            state     <= RESP;
            rsp_fault <= 1'b1;
            rsp_cause <= CAUSE_TIMEOUT;
            rsp_data  <= '0;
          end else if (mem_rvalid) begin
            state    <= RESP;
            rsp_data <= ext;
          end
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_unit.sv
// Self-checking bench for load_unit: behavioural model plus directed cases.
// Runs with TIMEOUT_CYCLES=8; honours LOAD_MISALIGN_TRAP_EN if defined.
`timescale 1ns/1ps
module tb_load_unit;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [2:0]  ld_type = '0;
  logic [31:0] ld_addr = '0;
  logic [4:0]  ld_rd = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        rsp_fault;
  logic [1:0]  rsp_cause;

  always #5 clk = ~clk;

  load_unit #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .ld_valid (ld_valid), .ld_ready (ld_ready),
    .ld_type (ld_type), .ld_addr (ld_addr), .ld_rd (ld_rd),
    .mem_req (mem_req), .mem_addr (mem_addr),
    .mem_gnt (mem_gnt), .mem_rvalid (mem_rvalid),
    .mem_rdata (mem_rdata),
    .rsp_valid (rsp_valid), .rsp_ready (rsp_ready),
    .rsp_data (rsp_data), .rsp_rd (rsp_rd),
    .rsp_fault (rsp_fault), .rsp_cause (rsp_cause)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic        fault;
    logic [1:0]  cause;
    int          lat;
    logic        acc;
  } exp_t;

  // Outcome of one load from the rules: g = REQ cycles before the gnt cycle,
  // r = WAIT cycles before the rvalid cycle.
  function automatic exp_t model(input logic [2:0] t, input logic [31:0] a,
                                 input logic [31:0] w, input int g,
                                 input int r);
    exp_t e;
    logic [31:0] v;
    e.data = 0; e.fault = 0; e.cause = 0; e.lat = 0; e.acc = 1;
    if (!(t == 0 || t == 1 || t == 2 || t == 4 || t == 5)) begin
      e.fault = 1; e.cause = 3; e.lat = 1; e.acc = 0;
      return e;
    end
`ifdef LOAD_MISALIGN_TRAP_EN
    if (((t == 1 || t == 5) && (a % 2 != 0)) || (t == 2 && (a % 4 != 0))) begin
      e.fault = 1; e.cause = 1; e.lat = 1; e.acc = 0;
      return e;
    end
`endif
    if (g + r + 2 >= T) begin
      e.fault = 1; e.cause = 2; e.lat = T + 1;
      return e;
    end
    e.lat = g + r + 3;
    if (t == 0 || t == 4) begin
      v = (w >> (8 * (a % 4))) & 32'hFF;
      if (t == 0 && v >= 128) v = v - 256;
    end else if (t == 1 || t == 5) begin
      v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      if (t == 1 && v >= 32768) v = v - 65536;
    end else begin
      v = w;
    end
    e.data = v;
    return e;
  endfunction

  logic        armed = 1'b0;
  exp_t        ex;
  logic [31:0] ex_maddr;
  logic [4:0]  ex_rd;
  logic [31:0] got_data;
  logic [31:0] got_maddr;
  logic [1:0]  got_cause;
  int          got_lat;

  // Single compare process: outputs against the model every meaningful cycle
  always @(negedge clk) begin
    if (armed && rst_n) begin
      if (mem_req) check("mem_addr", mem_addr, ex_maddr);
      if (rsp_valid) begin
        check("rsp_data", rsp_data, ex.data);
        check("rsp_rd", 32'(rsp_rd), 32'(ex_rd));
        check("rsp_fault", 32'(rsp_fault), 32'(ex.fault));
        check("rsp_cause", 32'(rsp_cause), 32'(ex.cause));
        check("rdy_in_resp", 32'(ld_ready), 0);
      end
    end
  end

  task automatic do_load(input logic [2:0] t, input logic [31:0] a,
                         input logic [4:0] rd, input logic [31:0] w,
                         input int g, input int r, input int h,
                         input bit noise);
    int wt;
    bit seen;
    bit rv;
    wt = 0;
    while (!ld_ready && wt < 50) begin
      @(negedge clk);
      wt++;
    end
    if (!ld_ready) check("ld_ready_wait", 32'(ld_ready), 1);
    ex = model(t, a, w, g, r);
    ex_maddr = {a[31:2], 2'b00};
    ex_rd = rd;
    armed = 1'b1;
    ld_valid = 1'b1; ld_type = t; ld_addr = a; ld_rd = rd;
    @(negedge clk);
    ld_valid = 1'b0;
    ld_type = 3'($urandom);
    ld_addr = $urandom;
    ld_rd = 5'($urandom);
    seen = 0;
    got_lat = -1;
    got_data = 32'hDEAD_BEEF;
    got_maddr = 32'hDEAD_BEEF;
    got_cause = 0;
    for (int c = 1; c <= ex.lat + h; c++) begin
      if (rsp_valid && got_lat < 0) got_lat = c;
      if (rsp_valid) begin
        got_data = rsp_data;
        got_cause = rsp_cause;
      end
      if (mem_req) begin
        seen = 1;
        got_maddr = mem_addr;
      end
      if (c >= ex.lat) begin
        check("rsp_hold", 32'(rsp_valid), 1);
        check("ld_ready_hold", 32'(ld_ready), 0);
      end
      rv = ex.acc && (c == g + r + 2);
      mem_gnt = ex.acc && (c == g + 1);
      mem_rvalid = rv || (noise && (c <= g + 1 || c >= ex.lat)
                          && ($urandom_range(0, 1) == 1));
      mem_rdata = rv ? w : $urandom;
      rsp_ready = (c >= ex.lat + h);
      @(negedge clk);
    end
    check("back_idle", 32'(ld_ready), 1);
    check("rsp_dropped", 32'(rsp_valid), 0);
    check("latency", 32'(got_lat), 32'(ex.lat));
    check("mem_access", 32'(seen), 32'(ex.acc));
    mem_gnt = 0;
    mem_rvalid = 0;
    rsp_ready = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] tv;
    repeat (2) @(negedge clk);
    check("rst_ld_ready", 32'(ld_ready), 1);
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_rd", 32'(rsp_rd), 0);
    check("rst_rsp_fault", 32'(rsp_fault), 0);
    check("rst_rsp_cause", 32'(rsp_cause), 0);
    rst_n = 1'b1;
    @(negedge clk);

    do_load(3'b000, 32'h1003, 5'd3, 32'h8000_0000, 0, 0, 0, 0);
    check("lb_data", got_data, 32'hFFFF_FF80);
    check("lb_lat", 32'(got_lat), 3);
    check("lb_maddr", got_maddr, 32'h1000);

    do_load(3'b101, 32'h2002, 5'd7, 32'hBEEF_1234, 0, 0, 4, 0);
    check("lhu_data", got_data, 32'h0000_BEEF);

    do_load(3'b010, 32'h3001, 5'd9, 32'hCAFE_F00D, 0, 0, 1, 0);
`ifdef LOAD_MISALIGN_TRAP_EN
    check("lw_mis_lat", 32'(got_lat), 1);
    check("lw_mis_data", got_data, 0);
    check("lw_mis_cause", 32'(got_cause), 1);
`else
    check("lw_mis_data", got_data, 32'hCAFE_F00D);
    check("lw_mis_maddr", got_maddr, 32'h3000);
`endif

    do_load(3'b011, 32'h0040, 5'd1, 32'h1111_2222, 0, 0, 0, 0);
    check("ill_cause", 32'(got_cause), 3);
    check("ill_lat", 32'(got_lat), 1);

    do_load(3'b010, 32'h4000, 5'd4, 32'h5555_AAAA, 1000, 0, 3, 1);
    check("tmo_cause", 32'(got_cause), 2);
    check("tmo_lat", 32'(got_lat), 9);
    check("tmo_data", got_data, 0);
    do_load(3'b010, 32'h4004, 5'd5, 32'h1234_5678, 0, 0, 0, 1);
    check("post_tmo_data", got_data, 32'h1234_5678);

    // Reset while waiting for read data
    armed = 1'b0;
    ld_valid = 1'b1; ld_type = 3'b010; ld_addr = 32'h5000; ld_rd = 5'd6;
    @(negedge clk);
    ld_valid = 1'b0;
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    check("wait_no_req", 32'(mem_req), 0);
    check("wait_busy", 32'(ld_ready), 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ld_ready", 32'(ld_ready), 1);
    check("arst_mem_req", 32'(mem_req), 0);
    check("arst_mem_addr", mem_addr, 0);
    check("arst_rsp_valid", 32'(rsp_valid), 0);
    check("arst_rsp_data", rsp_data, 0);
    check("arst_rsp_rd", 32'(rsp_rd), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(ld_ready), 1);
    do_load(3'b100, 32'h6001, 5'd8, 32'h0000_FF00, 0, 1, 0, 0);
    check("lbu_ff", got_data, 32'h0000_00FF);

    for (int i = 0; i < 150; i++) begin
      tv = 3'($urandom_range(0, 7));
      if ((tv == 3 || tv == 6 || tv == 7) && $urandom_range(0, 2) != 0)
        tv = 3'b010;
      do_load(tv,
              ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom,
              5'($urandom), $urandom,
              $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_unit.md
Name: load_unit

Overview:
- Data-memory read path of the MEM stage; the load-side counterpart of the store write-mask/byte-lane logic.
- Accepts one load request at a time and issues a word-aligned read to data memory.
- Waits for the read data, then extracts and sign- or zero-extends the addressed byte, half or word.
- Returns the result, or a fault, to writeback over a valid/ready handshake.

Parameters:
- ADDR_W, 32, address width (matches `MEM_ADDR_BUS).
- DATA_W, 32, memory data width; only 32 is supported.
- TIMEOUT_CYCLES, 255, maximum cycles spent in REQ plus WAIT before a bus-timeout fault.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ld_valid  in  1  load request valid.
- ld_ready  out  1  unit can accept a request.
- ld_type  in  3  funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; all other codes are illegal.
- ld_addr  in  ADDR_W  byte address.
- ld_rd  in  5  destination-register tag.
- mem_req  out  1  read request to data memory.
- mem_addr  out  ADDR_W  word-aligned address, {addr[31:2],2'b00}.
- mem_gnt  in  1  request accepted.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  DATA_W  read word.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  DATA_W  extended load result.
- rsp_rd  out  5  captured tag.
- rsp_fault  out  1  load faulted.
- rsp_cause  out  2  fault cause: 00 none, 01 misaligned, 10 bus timeout, 11 illegal type.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, so ld_ready=1.
  - mem_req=0, mem_addr=0, rsp_valid=0, rsp_data=0, rsp_rd=0, rsp_fault=0, rsp_cause=00, timeout counter=0.
  - Reset mid-transaction abandons it; the memory side must tolerate a dropped request.
- Control signal decode: ld_ready=(state==IDLE); mem_req=(state==REQ); rsp_valid=(state==RESP).
- IDLE:
  - On ld_valid&&ld_ready, capture ld_type, ld_addr and ld_rd.
  - Illegal type -> RESP with fault cause 11.
  - Misaligned (LH/LHU with addr[0]=1; LW with addr[1:0]!=0), feature enabled -> RESP with cause 01.
  - Otherwise -> REQ.
- REQ:
  - mem_addr is held stable until mem_gnt.
  - mem_gnt=1 -> WAIT.
  - mem_rvalid is ignored in REQ.
- WAIT:
  - mem_rvalid=1 -> register the extracted data into rsp_data, then -> RESP with rsp_fault=0.
- Timeout counter:
  - Cleared on leaving IDLE; increments every cycle in REQ or WAIT.
  - On reaching TIMEOUT_CYCLES -> RESP with cause 10 and rsp_data=0.
  - If rvalid arrives in that same cycle, the timeout wins.
  - A late rvalid arriving in RESP or IDLE is dropped.
- RESP:
  - rsp_* is held stable until rsp_ready; then -> IDLE.
  - A new request is not accepted in the same cycle that the response is consumed.
- Extraction, with off=addr[1:0]:
  - LB/LBU: byte mem_rdata[8*off+:8], sign- or zero-extended.
  - LH/LHU: half mem_rdata[16*off[1]+:16], sign- or zero-extended.
  - LW: the full word.
- Latency:
  - Normal load, minimum (gnt in the first REQ cycle, rvalid in the next cycle): accept at cycle 0, rsp_valid at cycle 3.
  - Fault path: rsp_valid at cycle 1.
- rsp_data=0 whenever rsp_fault=1.

Optional Feature:
- Macro: LOAD_MISALIGN_TRAP_EN.
- Defined: misaligned loads fault with cause 01 and generate no memory access.
- Undefined:
  - Misaligned loads proceed; half offset uses addr[1] only, and LW ignores addr[1:0].
  - Cause 01 is never produced.
  - Misalignment is not checked at all.

Decomposition:
- Shared package load_pkg:
  - load-type enum (LB, LH, LW, LBU, LHU encodings);
  - fault-cause enum;
  - FSM state enum {IDLE, REQ, WAIT, RESP};
  - localparam DEFAULT_TIMEOUT.
- Sub-module load_data_extractor: purely combinational, taking ld_type, off and rdata and producing the extended data. It is the read-side mirror of the write-mask generator and is unit-testable standalone.
- load_unit contains the FSM, the timeout counter and the capture registers.

Test Plan:
- LB, addr 0x1003, rdata 0x80_00_00_00, gnt immediate, rvalid next cycle -> rsp_data 0xFFFF_FF80, mem_addr 0x1000, rsp_valid 3 cycles after accept.
- LHU, addr 0x2002, rdata 0xBEEF_1234, rsp_ready low for 4 cycles -> rsp_data 0x0000_BEEF held stable throughout; returns to IDLE after ready; ld_ready=0 during hold.
- LW, addr 0x3001, with LOAD_MISALIGN_TRAP_EN -> no mem_req, rsp_fault=1, cause 01, rsp_data 0 at cycle 1. Without the macro -> mem_addr 0x3000, full word returned.
- ld_type 011 -> fault cause 11, no memory access.
- gnt withheld indefinitely, TIMEOUT_CYCLES=8 -> cause 10 after 8 cycles in REQ. A late rvalid is then ignored, and the next LW returns its own data correctly.
- Assert rst_n low while in WAIT -> all outputs return to reset values immediately; after release, ld_ready=1 and a fresh LBU of 0xFF returns 0x0000_00FF.
